// File: rtl/enc_home_pkg.sv
// ---------------------------------------------------------------------------
// enc_home_pkg
// Shared types for the encoder homing / index-supervision sequencer.
//   state_t      : sequencer states
//   fault_code_t : reason code published on fault_code
//   FAULT_CODE_W : width of the fault_code port
//   BLANK_CYCLES : cycles z_flag is ignored after each z_clr pulse in HOMED
// ---------------------------------------------------------------------------
package enc_home_pkg;

    localparam int FAULT_CODE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        CLR,
        ARM,
        HOMED,
        FAULT
    } state_t;

    typedef enum logic [FAULT_CODE_W-1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_ENC_ERR = 2'd2
    } fault_code_t;

    // The z_clr cycle itself plus one more, so a flag that the encoder has
    // not yet dropped after the clear is never taken as a new index.
    localparam logic [1:0] BLANK_CYCLES = 2'd2;

endpackage

// File: rtl/enc_index_check.sv
// ---------------------------------------------------------------------------
// enc_index_check
// Combinational index-spacing window check.
//   z_pos  : in  32 signed, position captured at the newest index pulse
//   last_z : in  32 signed, position captured at the previous index pulse
//   pass   : out 1, spacing is within REV_TOL of 0 or of COUNTS_PER_REV
// A spacing near zero is a legal reversal back across the same index.
// ---------------------------------------------------------------------------
module enc_index_check
    import enc_home_pkg::*;
#(
    parameter int COUNTS_PER_REV = 4000,
    parameter int REV_TOL        = 2
) (
    input  logic signed [31:0] z_pos,
    input  logic signed [31:0] last_z,
    output logic               pass
);

    logic signed [32:0] diff;      // z_pos - last_z, cannot overflow in 33 bits
    logic        [32:0] diff_mag;  // |diff|, at most 2^32-1
    logic signed [33:0] dev;       // |diff| - COUNTS_PER_REV
    logic        [33:0] dev_mag;   // ||diff| - COUNTS_PER_REV|

    assign diff     = {z_pos[31], z_pos} - {last_z[31], last_z};
    assign diff_mag = diff[32] ? 33'(-diff) : 33'(diff);
    assign dev      = $signed({1'b0, diff_mag}) - 34'(COUNTS_PER_REV);
    assign dev_mag  = dev[33] ? 34'(-dev) : 34'(dev);

    assign pass = (diff_mag <= 33'(REV_TOL)) || (dev_mag <= 34'(REV_TOL));

endmodule

// File: rtl/enc_home_ctrl.sv
// ---------------------------------------------------------------------------
// enc_home_ctrl
// Homing and index-supervision sequencer for one quadrature channel with a
// Z index. Arms Z capture on command, latches the index as the axis origin,
// publishes an origin-relative position and afterwards checks every index
// pulse against the expected counts per revolution.
//   clock, sclr  : clock, synchronous active-high reset
//   cmd_home     : in  pulse, start / restart homing
//   cmd_abort    : in  pulse, return to IDLE
//   enc_ready    : in  encoder counter enabled
//   enc_error    : in  quadrature sequence error
//   enc_count    : in  32 signed raw count
//   z_pos        : in  32 signed count captured at last Z
//   z_flag       : in  Z captured since last clear
//   z_clr        : out pulse clearing the encoder's z_flag
//   busy         : out in WAIT_RDY, CLR or ARM
//   homed        : out in HOMED
//   lost         : out pulse, HOMED left because enc_ready dropped
//   fault        : out in FAULT
//   fault_code   : out 2, 0 none / 1 timeout / 2 encoder error
//   index_err    : out sticky, an index spacing check failed
//   position     : out 32 signed, enc_count - origin (registered)
// ---------------------------------------------------------------------------
module enc_home_ctrl
    import enc_home_pkg::*;
#(
    parameter int COUNTS_PER_REV = 4000,
    parameter int REV_TOL        = 2,
    parameter int TIMEOUT_W      = 24
) (
    input  logic                    clock,
    input  logic                    sclr,
    input  logic                    cmd_home,
    input  logic                    cmd_abort,
    input  logic                    enc_ready,
    input  logic                    enc_error,
    input  logic signed [31:0]      enc_count,
    input  logic signed [31:0]      z_pos,
    input  logic                    z_flag,
    output logic                    z_clr,
    output logic                    busy,
    output logic                    homed,
    output logic                    lost,
    output logic                    fault,
    output logic [FAULT_CODE_W-1:0] fault_code,
    output logic                    index_err,
    output logic signed [31:0]      position
);

    state_t                 state, state_next;
    fault_code_t            code, code_next;
    logic signed [31:0]     origin, origin_next;
    logic signed [31:0]     last_z, last_z_next;
    logic [TIMEOUT_W-1:0]   tmo, tmo_next, tmo_inc;
    logic [1:0]             blank, blank_next;
    logic                   z_clr_next;
    logic                   lost_next;
    logic                   index_err_next;
    logic                   spacing_ok;

    enc_index_check #(
        .COUNTS_PER_REV (COUNTS_PER_REV),
        .REV_TOL        (REV_TOL)
    ) u_index_check (
        .z_pos  (z_pos),
        .last_z (last_z),
        .pass   (spacing_ok)
    );

    // Saturating increment; the all-ones value is the timeout point.
    assign tmo_inc = (tmo == {TIMEOUT_W{1'b1}}) ? tmo : tmo + 1'b1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next     = state;
        code_next      = code;
        origin_next    = origin;
        last_z_next    = last_z;
        tmo_next       = tmo;
        blank_next     = (blank != 2'd0) ? blank - 2'd1 : 2'd0;
        z_clr_next     = 1'b0;
        lost_next      = 1'b0;
        index_err_next = index_err;

        if (cmd_abort) begin
            // Abort in IDLE simply keeps IDLE (and swallows a coincident home).
            state_next = IDLE;
            code_next  = FC_NONE;
        end else if (enc_error && (state inside {WAIT_RDY, CLR, ARM, HOMED})) begin
            state_next = FAULT;
            code_next  = FC_ENC_ERR;
        end else if (cmd_home) begin
            // Every accepted home request starts a fresh supervision epoch.
            state_next     = WAIT_RDY;
            code_next      = FC_NONE;
            index_err_next = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                WAIT_RDY: begin
                    if (enc_ready) begin
                        state_next = CLR;
                        z_clr_next = 1'b1;
                    end
                end
                CLR: begin
                    tmo_next   = '0;
                    state_next = enc_ready ? ARM : WAIT_RDY;
                end
                ARM: begin
                    tmo_next = tmo_inc;
                    if (!enc_ready) begin
                        // The counter was reset under us; any capture is void.
                        state_next = WAIT_RDY;
                    end else if (z_flag) begin
                        origin_next = z_pos;
                        last_z_next = z_pos;
                        state_next  = HOMED;
                        z_clr_next  = 1'b1;
                        blank_next  = BLANK_CYCLES;
                    end else if (tmo_inc == {TIMEOUT_W{1'b1}}) begin
                        state_next = FAULT;
                        code_next  = FC_TIMEOUT;
                    end
                end
                HOMED: begin
                    if (!enc_ready) begin
                        state_next = IDLE;
                        lost_next  = 1'b1;
                    end else if (z_flag && (blank == 2'd0)) begin
                        if (!spacing_ok) begin
                            index_err_next = 1'b1;
                        end
                        last_z_next = z_pos;
                        z_clr_next  = 1'b1;
                        blank_next  = BLANK_CYCLES;
                    end
                end
                FAULT: ;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state     <= IDLE;
            code      <= FC_NONE;
            origin    <= '0;
            last_z    <= '0;
            tmo       <= '0;
            blank     <= 2'd0;
            z_clr     <= 1'b0;
            lost      <= 1'b0;
            index_err <= 1'b0;
            position  <= '0;
        end else begin
            state     <= state_next;
            code      <= code_next;
            origin    <= origin_next;
            last_z    <= last_z_next;
            tmo       <= tmo_next;
            blank     <= blank_next;
            z_clr     <= z_clr_next;
            lost      <= lost_next;
            index_err <= index_err_next;
            position  <= enc_count - origin;
        end
    end

    assign busy       = (state == WAIT_RDY) || (state == CLR) || (state == ARM);
    assign homed      = (state == HOMED);
    assign fault      = (state == FAULT);
    assign fault_code = code;

endmodule

// File: tb/tb_enc_home_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enc_home_ctrl
// Directed bench for enc_home_ctrl with a cycle-level behavioural model of
// the homing rules, compared against every output on every cycle after the
// initial reset, plus hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_enc_home_ctrl;

    localparam int CPR = 4000;
    localparam int TOL = 2;
    localparam int TW  = 4;

    // Model modes (independent of the RTL encoding).
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_CLR   = 2;
    localparam int M_ARM   = 3;
    localparam int M_HOMED = 4;
    localparam int M_FAULT = 5;

    logic               clock = 1'b0;
    logic               sclr, cmd_home, cmd_abort, enc_ready, enc_error, z_flag;
    logic signed [31:0] enc_count, z_pos;
    logic               z_clr, busy, homed, lost, fault, index_err;
    logic [1:0]         fault_code;
    logic signed [31:0] position;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    enc_home_ctrl #(
        .COUNTS_PER_REV (CPR),
        .REV_TOL        (TOL),
        .TIMEOUT_W      (TW)
    ) dut (
        .clock      (clock),
        .sclr       (sclr),
        .cmd_home   (cmd_home),
        .cmd_abort  (cmd_abort),
        .enc_ready  (enc_ready),
        .enc_error  (enc_error),
        .enc_count  (enc_count),
        .z_pos      (z_pos),
        .z_flag     (z_flag),
        .z_clr      (z_clr),
        .busy       (busy),
        .homed      (homed),
        .lost       (lost),
        .fault      (fault),
        .fault_code (fault_code),
        .index_err  (index_err),
        .position   (position)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                 m_mode = M_IDLE;
    int                 m_arm_cycles = 0;
    int                 m_age = 0;     // cycles since the last z_clr in HOMED
    int                 m_code = 0;
    bit                 m_zclr = 0, m_lost = 0, m_ierr = 0;
    logic signed [31:0] m_origin = 0, m_last = 0, m_pos = 0;

    task automatic model_step();
        longint d, ad, dev;
        m_zclr = 0;
        m_lost = 0;
        if (sclr) begin
            m_mode = M_IDLE; m_origin = 0; m_last = 0; m_pos = 0;
            m_code = 0; m_ierr = 0; m_arm_cycles = 0; m_age = 0;
            return;
        end
        m_pos = enc_count - m_origin;
        if (cmd_abort) begin
            m_mode = M_IDLE; m_code = 0;
        end else if (enc_error && m_mode != M_IDLE && m_mode != M_FAULT) begin
            m_mode = M_FAULT; m_code = 2;
        end else if (cmd_home) begin
            m_mode = M_WAIT; m_code = 0; m_ierr = 0;
        end else begin
            case (m_mode)
                M_WAIT: if (enc_ready) begin m_mode = M_CLR; m_zclr = 1; end
                M_CLR: begin
                    m_arm_cycles = 0;
                    m_mode = enc_ready ? M_ARM : M_WAIT;
                end
                M_ARM: begin
                    m_arm_cycles++;
                    if (!enc_ready) m_mode = M_WAIT;
                    else if (z_flag) begin
                        m_origin = z_pos; m_last = z_pos; m_mode = M_HOMED;
                        m_zclr = 1; m_age = 0;
                    end else if (m_arm_cycles == (1 << TW) - 1) begin
                        m_mode = M_FAULT; m_code = 1;
                    end
                end
                M_HOMED: begin
                    if (!enc_ready) begin
                        m_mode = M_IDLE; m_lost = 1;
                    end else if (m_age >= 2 && z_flag) begin
                        d   = longint'(z_pos) - longint'(m_last);
                        ad  = (d < 0) ? -d : d;
                        dev = ad - CPR;
                        if (dev < 0) dev = -dev;
                        if (!(ad <= TOL || dev <= TOL)) m_ierr = 1;
                        m_last = z_pos; m_zclr = 1; m_age = 0;
                    end else begin
                        m_age++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("cyc_z_clr",      64'(z_clr),      64'(m_zclr));
        check("cyc_busy",       64'(busy),       64'(m_mode == M_WAIT || m_mode == M_CLR || m_mode == M_ARM));
        check("cyc_homed",      64'(homed),      64'(m_mode == M_HOMED));
        check("cyc_lost",       64'(lost),       64'(m_lost));
        check("cyc_fault",      64'(fault),      64'(m_mode == M_FAULT));
        check("cyc_fault_code", 64'(fault_code), 64'(m_code));
        check("cyc_index_err",  64'(index_err),  64'(m_ierr));
        check("cyc_position",   64'(unsigned'(position)), 64'(unsigned'(m_pos)));
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        if (cmp_en) compare_all();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_home();
        cmd_home = 1'b1;
        tick();
        cmd_home = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        sclr = 1'b1; cmd_home = 1'b0; cmd_abort = 1'b0; enc_ready = 1'b1;
        enc_error = 1'b0; z_flag = 1'b0; enc_count = 0; z_pos = 0;
        tick(); tick();
        check("rst_homed",      64'(homed), 64'd0);
        check("rst_busy",       64'(busy), 64'd0);
        check("rst_z_clr",      64'(z_clr), 64'd0);
        check("rst_fault_code", 64'(fault_code), 64'd0);
        check("rst_position",   64'(unsigned'(position)), 64'd0);
        sclr = 1'b0;
        cmp_en = 1'b1;

        // 1: homing on z_pos=1234, index 10 cycles after CLR
        enc_count = 1300; z_pos = 1234;
        pulse_home();
        check("t1_busy_wait", 64'(busy), 64'd1);
        tick();
        check("t1_zclr_in_clr", 64'(z_clr), 64'd1);
        repeat (10) tick();
        z_flag = 1'b1;
        tick();
        z_flag = 1'b0;
        check("t1_homed", 64'(homed), 64'd1);
        check("t1_zclr_home", 64'(z_clr), 64'd1);
        tick();
        check("t1_position", 64'(unsigned'(position)), 64'd66);

        // 2: spacing 4001 passes, flag held through blanking ignored, 4005 fails
        repeat (3) tick();
        z_pos = 5235; z_flag = 1'b1;
        tick();
        check("t2_check_zclr", 64'(z_clr), 64'd1);
        check("t2_ierr_4001", 64'(index_err), 64'd0);
        z_pos = 77777;
        tick();
        check("t2_blank1_zclr", 64'(z_clr), 64'd0);
        tick();
        check("t2_blank2_zclr", 64'(z_clr), 64'd0);
        check("t2_blank_ierr", 64'(index_err), 64'd0);
        z_flag = 1'b0;
        tick();
        z_pos = 9240; z_flag = 1'b1;
        tick();
        z_flag = 1'b0;
        check("t2_ierr_4005", 64'(index_err), 64'd1);
        check("t2_still_homed", 64'(homed), 64'd1);
        enc_count = 5300;
        tick();
        check("t2_position", 64'(unsigned'(position)), 64'd4066);

        // 3: timeout after 15 ARM cycles, cleared by cmd_home
        pulse_home();
        tick();
        check("t3_zclr_in_clr", 64'(z_clr), 64'd1);
        n = 0;
        while (!fault && n < 40) begin
            tick();
            n++;
        end
        check("t3_timeout_cycles", 64'(n), 64'd16);
        check("t3_fault_code", 64'(fault_code), 64'd1);
        check("t3_busy_fault", 64'(busy), 64'd0);
        pulse_home();
        check("t3_busy_rehome", 64'(busy), 64'd1);
        check("t3_code_cleared", 64'(fault_code), 64'd0);

        // 4: home at 2000, lose enc_ready while homed, then while armed
        tick();
        tick();
        enc_count = 2500; z_pos = 2000; z_flag = 1'b1;
        tick();
        z_flag = 1'b0;
        check("t4_homed", 64'(homed), 64'd1);
        tick();
        check("t4_position", 64'(unsigned'(position)), 64'd500);
        enc_ready = 1'b0;
        tick();
        enc_ready = 1'b1;
        check("t4_lost", 64'(lost), 64'd1);
        check("t4_homed_lost", 64'(homed), 64'd0);
        check("t4_idle_busy", 64'(busy), 64'd0);
        tick();
        check("t4_lost_pulse", 64'(lost), 64'd0);
        pulse_home();
        tick();
        tick();
        tick();
        enc_ready = 1'b0;
        tick();
        enc_ready = 1'b1;
        check("t4_arm_drop_busy", 64'(busy), 64'd1);
        check("t4_arm_drop_zclr", 64'(z_clr), 64'd0);
        tick();
        check("t4_rearm_zclr", 64'(z_clr), 64'd1);

        // 5: enc_error and z_flag together in ARM
        tick();
        tick();
        enc_error = 1'b1; z_flag = 1'b1; z_pos = 555;
        tick();
        enc_error = 1'b0; z_flag = 1'b0;
        check("t5_fault", 64'(fault), 64'd1);
        check("t5_fault_code", 64'(fault_code), 64'd2);
        check("t5_homed", 64'(homed), 64'd0);
        tick();
        check("t5_origin_kept", 64'(unsigned'(position)), 64'd500);

        // 6: abort beats home while homed; sclr mid-ARM
        pulse_home();
        tick();
        tick();
        z_pos = 3000; z_flag = 1'b1;
        tick();
        z_flag = 1'b0;
        check("t6_homed", 64'(homed), 64'd1);
        cmd_abort = 1'b1; cmd_home = 1'b1;
        tick();
        cmd_abort = 1'b0; cmd_home = 1'b0;
        check("t6_abort_homed", 64'(homed), 64'd0);
        check("t6_abort_busy", 64'(busy), 64'd0);
        check("t6_abort_fault", 64'(fault), 64'd0);
        pulse_home();
        tick();
        tick();
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("t6_sclr_busy", 64'(busy), 64'd0);
        check("t6_sclr_z_clr", 64'(z_clr), 64'd0);
        check("t6_sclr_position", 64'(unsigned'(position)), 64'd0);

        // enc_error while IDLE is ignored
        enc_error = 1'b1;
        tick();
        enc_error = 1'b0;
        check("idle_err_fault", 64'(fault), 64'd0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
